tilelink_ul_master: RTL
=======================

# tilelink_ul_master

Single-outstanding TileLink Uncached Lightweight (TL-UL) initiator that pairs with `tilelink_ul_slave_top`. It accepts read and write commands on a simple valid/ready command port and drives the A channel as Get, PutFullData or PutPartialData. It then collects the matching D-channel response and returns data and status on a response port. It also detects response timeouts and drops stray responses.

## Interface
Parameters:
- TL_ADDR_WIDTH, 64, address width
- TL_DATA_WIDTH, 64, data width
- TL_STRB_WIDTH, TL_DATA_WIDTH/8, byte-mask width
- TL_SOURCE_WIDTH, 3, source ID width
- TL_SINK_WIDTH, 3, sink ID width
- TL_OPCODE_WIDTH, 3, opcode width
- TL_PARAM_WIDTH, 3, param width
- TL_SIZE_WIDTH, 8, size width
- TIMEOUT_CYCLES, 256, D-wait cycles before the transaction is abandoned; must be ≥1

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  TL_ADDR_WIDTH  byte address
- cmd_size  in  TL_SIZE_WIDTH  log2 bytes
- cmd_mask  in  TL_STRB_WIDTH  byte enables
- cmd_data  in  TL_DATA_WIDTH  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  TL_DATA_WIDTH  read data; 0 for writes
- rsp_error  out  1  d_error, or timeout
- rsp_timeout  out  1  transaction abandoned by timeout
- a_valid, a_ready, a_opcode, a_param, a_address, a_size, a_mask, a_data, a_source: TL-UL A channel
  - a_ready is an input; the rest are outputs.
  - Widths follow the parameters.
- d_valid, d_ready, d_opcode, d_param, d_size, d_sink, d_source, d_data, d_error: TL-UL D channel
  - d_ready is an output; the rest are inputs.
- stray_rsp  out  1  sticky; set when a D beat with a non-matching source is dropped; cleared only by rst

## Operation
- States: IDLE, A_SEND, D_WAIT, RSP.
- **IDLE:** cmd_ready=1. On cmd_valid, latch the command and go to A_SEND.
- **A_SEND:** a_valid=1 with registered fields.
  - a_opcode: Get (4) for reads. For writes, PutFullData (0) when cmd_mask is all ones, else PutPartialData (1).
  - a_param=0.
  - a_source = current source counter.
  - a_data = cmd_data for writes, 0 for reads.
  - All A fields are stable while a_valid=1 and a_ready=0.
  - On a_ready, go to D_WAIT and clear the timeout counter.
- **D_WAIT:** d_ready=1.
  - A D beat with d_source==a_source is the response.
    - Capture d_data; capture 0 if d_opcode is AccessAck (0) instead of AccessAckData (1).
    - Capture d_error; clear rsp_timeout.
    - Go to RSP.
  - A D beat with a mismatched source is consumed and dropped, and stray_rsp is set. The state does not change.
  - The counter increments every D_WAIT cycle without a matching beat. On reaching TIMEOUT_CYCLES-1, go to RSP with rsp_error=1, rsp_timeout=1 and rsp_data=0.
- **RSP:** rsp_valid=1 and fields are held. On rsp_ready, go to IDLE.
- The source counter increments, wrapping modulo 2^TL_SOURCE_WIDTH, each time RSP is left. A late response to an abandoned transaction therefore mismatches and is dropped.
- Reset in any state: return to IDLE, source counter=0, stray_rsp=0. Any in-flight transaction is discarded with no response.

## Timing
- Reset values: cmd_ready=1 (after reset deasserts), a_valid=0, d_ready=0, rsp_valid=0, and every data, opcode, mask, error and flag output = 0.
- Command accepted at edge N → a_valid=1 in cycle N+1.
- A handshake at edge M → d_ready=1 from cycle M+1.
- A matching D beat at edge K → rsp_valid=1 in cycle K+1.
- Minimum command-to-response latency is 3 cycles with a_ready and d_valid held high.
- cmd_ready=0 outside IDLE. A new command may be accepted in the cycle after the rsp handshake.
- d_valid arriving in A_SEND is not accepted (d_ready=0).
- All outputs are registered or pure state decodes; there is no combinational path from any input to any output.

## Structure
- Shared package `tilelink_ul_pkg`:
  - A opcode constants: PUT_FULL=0, PUT_PARTIAL=1, GET=4.
  - D opcode constants: ACCESS_ACK=0, ACCESS_ACK_DATA=1.
  - The state enum.
  - Defaults for the width parameters, also used by `tilelink_ul_slave_top`.
- No sub-module is needed; the timeout counter is inline.

## Test plan
- **Write then read, full mask:** write 0xDEADBEEFCAFEBABE to 0x10, mask 0xFF, against the slave. Required: a_opcode=0, rsp_error=0. A following read of 0x10 must show a_opcode=4 and rsp_data=0xDEADBEEFCAFEBABE, 3 cycles after acceptance.
- **Partial write:** write 0x123456789ABCDEF0 to 0x20, mask 0x0F. Required: a_opcode=1. A following read must return lower 32 bits = 0x9ABCDEF0.
- **Back-pressure:**
  - Hold a_ready=0 for 4 cycles: A fields must stay stable.
  - Hold rsp_ready=0 for 3 cycles: rsp fields must stay stable.
  - Then read 0x30 after writing 0xBADDCAFEBEEF1234: it must return the written value.
- **Timeout:** with TIMEOUT_CYCLES=8, never send a D beat. Required: rsp_valid with rsp_error=1, rsp_timeout=1, rsp_data=0, 8 cycles after the A handshake. A late D beat with the old source must then set stray_rsp=1 and produce no response.
- **Slave error:** the slave returns d_error=1 → rsp_error=1 and rsp_timeout=0.
- **Source wrap and mid-transaction reset:**
  - Run 9 transactions: a_source must go 0..7 then 0.
  - Assert rst during D_WAIT: next cycle a_valid=0, d_ready=0, rsp_valid=0, cmd_ready=1, and a_source restarts at 0.

Source files
------------

// File: rtl/tilelink_ul_pkg.sv
// Shared TL-UL definitions: opcode encodings, initiator state type and
// default channel widths used by both the initiator and the slave.
package tilelink_ul_pkg;

  localparam int TL_ADDR_WIDTH_DEF   = 64;
  localparam int TL_DATA_WIDTH_DEF   = 64;
  localparam int TL_STRB_WIDTH_DEF   = TL_DATA_WIDTH_DEF / 8;
  localparam int TL_SOURCE_WIDTH_DEF = 3;
  localparam int TL_SINK_WIDTH_DEF   = 3;
  localparam int TL_OPCODE_WIDTH_DEF = 3;
  localparam int TL_PARAM_WIDTH_DEF  = 3;
  localparam int TL_SIZE_WIDTH_DEF   = 8;

  // A channel opcodes
  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;

  // D channel opcodes
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_SEND = 2'd1,
    D_WAIT = 2'd2,
    RSP    = 2'd3
  } tl_state_e;

  // Writes with every byte enabled are full puts; anything else is partial.
  function automatic logic [2:0] a_opcode_for(input logic write, input logic full_mask);
    if (!write) begin
      return GET;
    end
    return full_mask ? PUT_FULL : PUT_PARTIAL;
  endfunction

endpackage

// File: rtl/tilelink_ul_master.sv
// Single-outstanding TL-UL initiator: takes one command, issues it on the
// A channel, waits for the matching D beat (or a timeout) and presents the
// result on the response port. Non-matching D beats are dropped and flagged.
module tilelink_ul_master
  import tilelink_ul_pkg::*;
#(
  parameter int TL_ADDR_WIDTH   = TL_ADDR_WIDTH_DEF,
  parameter int TL_DATA_WIDTH   = TL_DATA_WIDTH_DEF,
  parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int TL_SOURCE_WIDTH = TL_SOURCE_WIDTH_DEF,
  parameter int TL_SINK_WIDTH   = TL_SINK_WIDTH_DEF,
  parameter int TL_OPCODE_WIDTH = TL_OPCODE_WIDTH_DEF,
  parameter int TL_PARAM_WIDTH  = TL_PARAM_WIDTH_DEF,
  parameter int TL_SIZE_WIDTH   = TL_SIZE_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  // command port
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [TL_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [TL_SIZE_WIDTH-1:0]   cmd_size,
  input  logic [TL_STRB_WIDTH-1:0]   cmd_mask,
  input  logic [TL_DATA_WIDTH-1:0]   cmd_data,
  // response port
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [TL_DATA_WIDTH-1:0]   rsp_data,
  output logic                       rsp_error,
  output logic                       rsp_timeout,
  // A channel
  output logic                       a_valid,
  input  logic                       a_ready,
  output logic [TL_OPCODE_WIDTH-1:0] a_opcode,
  output logic [TL_PARAM_WIDTH-1:0]  a_param,
  output logic [TL_ADDR_WIDTH-1:0]   a_address,
  output logic [TL_SIZE_WIDTH-1:0]   a_size,
  output logic [TL_STRB_WIDTH-1:0]   a_mask,
  output logic [TL_DATA_WIDTH-1:0]   a_data,
  output logic [TL_SOURCE_WIDTH-1:0] a_source,
  // D channel
  input  logic                       d_valid,
  output logic                       d_ready,
  input  logic [TL_OPCODE_WIDTH-1:0] d_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]  d_param,
  input  logic [TL_SIZE_WIDTH-1:0]   d_size,
  input  logic [TL_SINK_WIDTH-1:0]   d_sink,
  input  logic [TL_SOURCE_WIDTH-1:0] d_source,
  input  logic [TL_DATA_WIDTH-1:0]   d_data,
  input  logic                       d_error,
  // status
  output logic                       stray_rsp
);

  localparam int TIMER_WIDTH  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int TIMEOUT_LAST = TIMEOUT_CYCLES - 1;

  tl_state_e state_reg, state_next;

  logic [TL_OPCODE_WIDTH-1:0] a_opcode_reg;
  logic [TL_ADDR_WIDTH-1:0]   a_address_reg;
  logic [TL_SIZE_WIDTH-1:0]   a_size_reg;
  logic [TL_STRB_WIDTH-1:0]   a_mask_reg;
  logic [TL_DATA_WIDTH-1:0]   a_data_reg;
  logic [TL_SOURCE_WIDTH-1:0] source_reg;
  logic [TIMER_WIDTH-1:0]     timer_reg;
  logic [TL_DATA_WIDTH-1:0]   rsp_data_reg;
  logic                       rsp_error_reg;
  logic                       rsp_timeout_reg;
  logic                       stray_reg;

  logic d_match;
  logic d_stray;
  logic timeout_hit;
  logic unused_inputs;

  // Sideband D fields carry nothing this initiator needs.
  assign unused_inputs = ^{d_param, d_size, d_sink};

  assign d_match = d_valid && (d_source == source_reg);
  assign d_stray = d_valid && !d_match;
  // The timer counts D_WAIT cycles without a response; the transaction is
  // abandoned in the cycle whose increment would bring it to TIMEOUT_CYCLES-1.
  assign timeout_hit = (int'(timer_reg) + 1) >= TIMEOUT_LAST;

  assign a_opcode    = a_opcode_reg;
  assign a_param     = '0;
  assign a_address   = a_address_reg;
  assign a_size      = a_size_reg;
  assign a_mask      = a_mask_reg;
  assign a_data      = a_data_reg;
  assign a_source    = source_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_error   = rsp_error_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign stray_rsp   = stray_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state selection and handshake outputs decoded from the state.
  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    a_valid    = 1'b0;
    d_ready    = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = A_SEND;
      end
      A_SEND: begin
        a_valid = 1'b1;
        if (a_ready) state_next = D_WAIT;
      end
      D_WAIT: begin
        d_ready = 1'b1;
        if (d_match || timeout_hit) state_next = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch, source/timeout counters, response capture and stray flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_opcode_reg    <= '0;
      a_address_reg   <= '0;
      a_size_reg      <= '0;
      a_mask_reg      <= '0;
      a_data_reg      <= '0;
      source_reg      <= '0;
      timer_reg       <= '0;
      rsp_data_reg    <= '0;
      rsp_error_reg   <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      stray_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            a_opcode_reg  <= TL_OPCODE_WIDTH'(a_opcode_for(cmd_write, &cmd_mask));
            a_address_reg <= cmd_addr;
            a_size_reg    <= cmd_size;
            a_mask_reg    <= cmd_mask;
            a_data_reg    <= cmd_write ? cmd_data : '0;
          end
        end
        A_SEND: begin
          if (a_ready) timer_reg <= '0;
        end
        D_WAIT: begin
          if (d_match) begin
            rsp_data_reg    <= (d_opcode == TL_OPCODE_WIDTH'(ACCESS_ACK_DATA)) ? d_data : '0;
            rsp_error_reg   <= d_error;
            rsp_timeout_reg <= 1'b0;
          end else begin
            if (d_stray) stray_reg <= 1'b1;
            if (timeout_hit) begin
              rsp_data_reg    <= '0;
              rsp_error_reg   <= 1'b1;
              rsp_timeout_reg <= 1'b1;
            end else begin
              timer_reg <= timer_reg + TIMER_WIDTH'(1);
            end
          end
        end
        RSP: begin
          if (rsp_ready) source_reg <= source_reg + TL_SOURCE_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
